// File: rtl/imem_arb_pkg.sv
// Shared types and default widths for the instruction-memory read arbiter.
package imem_arb_pkg;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   typedef enum logic [0:0] {FETCH_PRI, DBG_FORCE} arb_state_t;

   typedef struct packed {
      logic              req;
      logic [ADDR_W-1:0] addr;
   } rd_req_t;
endpackage

// File: rtl/imem_arbiter_if.sv
// One read requester's handshake: level req/addr in, comb gnt and registered rvalid/rdata back.
interface imem_arbiter_if #(
   parameter int ADDR_W = imem_arb_pkg::ADDR_W,
   parameter int DATA_W = imem_arb_pkg::DATA_W
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/imem_arb_starve_ctr.sv
// Counts consecutive denied debug cycles; force_nxt says the coming cycle belongs to debug.
module imem_arb_starve_ctr #(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic dbg_req,
   input  logic dbg_gnt,
   output logic force_nxt
);
   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = '0;
      if (dbg_req && !dbg_gnt)
         cnt_nxt = (starve_cnt == CNT_W'(STARVE_MAX)) ? starve_cnt : starve_cnt + CNT_W'(1);
   end

   // Looking at the next count lets the forced cycle land exactly STARVE_MAX denials in.
   assign force_nxt = (cnt_nxt == CNT_W'(STARVE_MAX));

   always_ff @(posedge clk) begin
      if (reset) starve_cnt <= '0;
      else       starve_cnt <= cnt_nxt;
   end
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: one imem read per cycle shared by fetch (priority) and debug, data registered.
// Define IMEM_ARB_STARVE_EN to add the debug starvation guard (imem_arb_starve_ctr + DBG_FORCE).
module imem_arbiter #(
   parameter int ADDR_W     = imem_arb_pkg::ADDR_W,
   parameter int DATA_W     = imem_arb_pkg::DATA_W,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   imem_arbiter_if.slave     fetch,
   imem_arbiter_if.slave     dbg,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_q
);
   import imem_arb_pkg::*;

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("imem_arbiter: STARVE_MAX must be in 1..15");
   end

   arb_state_t        state;
   rd_req_t           f_rq, d_rq;
   logic              f_gnt, d_gnt;
   logic              f_rvalid, d_rvalid;
   logic [DATA_W-1:0] f_rdata, d_rdata;

   assign f_rq = '{req: fetch.req, addr: fetch.addr};
   assign d_rq = '{req: dbg.req, addr: dbg.addr};

`ifdef IMEM_ARB_STARVE_EN
   arb_state_t state_nxt;
   logic       force_dbg;

   imem_arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX),
      .CNT_W      ($clog2(STARVE_MAX + 1))
   ) u_starve (
      .clk       (clk),
      .reset     (reset),
      .dbg_req   (d_rq.req),
      .dbg_gnt   (d_gnt),
      .force_nxt (force_dbg)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH_PRI;
      else       state <= state_nxt;
   end
`else
   assign state = FETCH_PRI;
`endif

   always_comb begin
      f_gnt    = 1'b0;
      d_gnt    = 1'b0;
      mem_addr = '0;
`ifdef IMEM_ARB_STARVE_EN
      state_nxt = force_dbg ? DBG_FORCE : FETCH_PRI;
`endif
      if (!reset) begin
         if (d_rq.req && (state == DBG_FORCE || !f_rq.req)) d_gnt = 1'b1;
         else if (f_rq.req)                                 f_gnt = 1'b1;
      end
      if (f_gnt)      mem_addr = f_rq.addr;
      else if (d_gnt) mem_addr = d_rq.addr;
   end

   // Only the winner's capture register loads; the loser keeps its last word.
   always_ff @(posedge clk) begin
      if (reset) begin
         f_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         f_rdata  <= '0;
         d_rdata  <= '0;
      end else begin
         f_rvalid <= f_gnt;
         d_rvalid <= d_gnt;
         if (f_gnt) f_rdata <= mem_q;
         if (d_gnt) d_rdata <= mem_q;
      end
   end

   assign fetch.gnt    = f_gnt;
   assign fetch.rvalid = f_rvalid;
   assign fetch.rdata  = f_rdata;
   assign dbg.gnt      = d_gnt;
   assign dbg.rvalid   = d_rvalid;
   assign dbg.rdata    = d_rdata;
endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized bench for imem_arbiter against a cycle-level winner/starvation model and an imem array.
module tb_imem_arbiter;
   localparam int SMAX = 4;
`ifdef IMEM_ARB_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  mem_addr;
   logic [31:0] mem_q;
   logic [31:0] mem [64];

   imem_arbiter_if fetch_if ();
   imem_arbiter_if dbg_if ();

   imem_arbiter #(.ADDR_W(6), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
      .clk      (clk),
      .reset    (reset),
      .fetch    (fetch_if),
      .dbg      (dbg_if),
      .mem_addr (mem_addr),
      .mem_q    (mem_q)
   );

   always #5 clk = ~clk;
   assign mem_q = mem[mem_addr];

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_dbg_gnt;
   logic        m_fv, m_dv;
   logic [31:0] m_fd, m_dd;
   int          denied;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, exp);
      end
   endtask

   // One clock: drive, check comb and registered outputs mid-cycle, then advance the model.
   task automatic cycle(input logic r, input logic fr, input logic [5:0] fa,
                        input logic dr, input logic [5:0] da);
      logic       ef, ed, forced;
      logic [5:0] ea;
      reset = r;
      fetch_if.req = fr; fetch_if.addr = fa;
      dbg_if.req   = dr; dbg_if.addr   = da;
      forced = STARVE_EN && (denied >= SMAX);
      ef = 1'b0; ed = 1'b0;
      if (!r) begin
         if (dr && (forced || !fr)) ed = 1'b1;
         else if (fr)               ef = 1'b1;
      end
      ea = ef ? fa : (ed ? da : 6'd0);
      #4;
      chk("fetch_gnt",    fetch_if.gnt,    ef);
      chk("dbg_gnt",      dbg_if.gnt,      ed);
      chk("mem_addr",     mem_addr,        ea);
      chk("fetch_rvalid", fetch_if.rvalid, m_fv);
      chk("fetch_rdata",  fetch_if.rdata,  m_fd);
      chk("dbg_rvalid",   dbg_if.rvalid,   m_dv);
      chk("dbg_rdata",    dbg_if.rdata,    m_dd);
      chk("state",        32'(dut.state),  {31'd0, forced});
      if (ed) n_dbg_gnt++;
      @(posedge clk); #1;
      if (r) begin
         m_fv = 1'b0; m_dv = 1'b0; m_fd = '0; m_dd = '0; denied = 0;
      end else begin
         m_fv = ef; m_dv = ed;
         if (ef) m_fd = mem[fa];
         if (ed) m_dd = mem[da];
         if (dr && !ed) denied = (denied + 1 > SMAX) ? SMAX : denied + 1;
         else           denied = 0;
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0]  = 32'hf8000000;
      mem[14] = 32'hcb0e01ce;
      mem[15] = 32'hb400004e;
      mem[20] = 32'h0;

      reset = 1'b1;
      fetch_if.req = 1'b0; fetch_if.addr = '0;
      dbg_if.req   = 1'b0; dbg_if.addr   = '0;
      repeat (2) @(posedge clk);
      #1;
      m_fv = 1'b0; m_dv = 1'b0; m_fd = '0; m_dd = '0; denied = 0;

      // Reset held with both requesting: no grants, cleared outputs.
      cycle(1'b1, 1'b1, 6'd3, 1'b1, 6'd4);
      cycle(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);

      // Fetch-only stream 0..18.
      for (int i = 0; i <= 18; i++) cycle(1'b0, 1'b1, 6'(i), 1'b0, 6'd0);
      cycle(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);

      // Debug-only read of word 14.
      cycle(1'b0, 1'b0, 6'd0, 1'b1, 6'd14);
      cycle(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);

      // Collision: fetch 15 wins, debug 20 served next cycle.
      cycle(1'b0, 1'b1, 6'd15, 1'b1, 6'd20);
      cycle(1'b0, 1'b0, 6'd0,  1'b1, 6'd20);
      cycle(1'b0, 1'b0, 6'd0,  1'b0, 6'd0);

      // Both held high for 20 cycles.
      n_dbg_gnt = 0;
      for (int i = 0; i < 20; i++)
         cycle(1'b0, 1'b1, 6'($urandom_range(0, 63)), 1'b1, 6'($urandom_range(0, 63)));
      chk("dbg_gnt_count_20", n_dbg_gnt, STARVE_EN ? 32'd4 : 32'd0);
      cycle(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);

      // Reset landing on a fetch grant cycle for word 14.
      cycle(1'b0, 1'b1, 6'd15, 1'b1, 6'd7);
      cycle(1'b0, 1'b1, 6'd14, 1'b1, 6'd7);
      cycle(1'b1, 1'b1, 6'd14, 1'b1, 6'd7);
      cycle(1'b0, 1'b0, 6'd0,  1'b0, 6'd0);
`ifdef IMEM_ARB_STARVE_EN
      chk("starve_cnt_rst", 32'(dut.u_starve.starve_cnt), 32'd0);
`endif

      // Random traffic with long debug holds and occasional resets.
      for (int i = 0; i < 600; i++)
         cycle($urandom_range(0, 59) == 0,
               $urandom_range(0, 3) != 0, 6'($urandom_range(0, 63)),
               $urandom_range(0, 4) != 0, 6'($urandom_range(0, 63)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
